alu_ctrl_data_mem: RTL and testbench

- Execute/memory-stage support block for the single-cycle MIPS CPU.
- Combines two functions:
  - the ALU control decoder, which maps the main control's 2-bit aluOP plus the instruction funct field to the 4-bit ALU operation code;
  - the word-addressed data memory, with combinational read and synchronous write.
- A simulation-only clock generator (sub-module clk_gen) drives clk in benches.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/alu_ctrl_decode.sv | 43 ++++
 rtl/alu_ctrl_data_mem.sv | 54 +++++
 tb/tb_alu_ctrl_data_mem.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the single-cycle MIPS datapath.
// Revision 1.0 - initial release.
`default_nettype none

package cpu_pkg;

  // Main-control ALU op classes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;

  // Operation codes understood by the main ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: maps alu_op and funct to the 4-bit ALU operation code.
// Revision 1.0 - initial release.
`default_nettype none

module alu_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] operation
);

  logic [3:0] rtype_op;

  always_comb begin
    rtype_op = ALU_ADD;
    case (funct)
      FUNCT_ADD: rtype_op = ALU_ADD;
      FUNCT_SUB: rtype_op = ALU_SUB;
      FUNCT_AND: rtype_op = ALU_AND;
      FUNCT_OR:  rtype_op = ALU_OR;
      FUNCT_NOR: rtype_op = ALU_NOR;
      FUNCT_SLT: rtype_op = ALU_SLT;
      FUNCT_SLL: rtype_op = ALU_SLL;
      FUNCT_SRL: rtype_op = ALU_SRL;
      default:   rtype_op = ALU_ADD;
    endcase
  end

  // The reserved class 2'b11 falls through to add.
  always_comb begin
    operation = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   operation = ALU_ADD;
      ALUOP_SUB:   operation = ALU_SUB;
      ALUOP_RTYPE: operation = rtype_op;
      default:     operation = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_ctrl_data_mem.sv
// alu_ctrl_data_mem: ALU control decoder plus word-addressed data memory.
// Revision 1.0 - initial release.
`default_nettype none

module alu_ctrl_data_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int ADDR_LSB = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  output logic [3:0]  operation,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] read_data
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int IDX_HI = ADDR_LSB + IDX_W - 1;

  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] index;
  logic             unused_addr_bits;

  alu_ctrl_decode u_alu_ctrl_decode (
    .alu_op    (alu_op),
    .funct     (funct),
    .operation (operation)
  );

  // Byte offset and bits above the array are dropped, so addresses wrap.
  assign index            = address[IDX_HI:ADDR_LSB];
  assign unused_addr_bits = ^{address[31:IDX_HI+1], address[ADDR_LSB-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (mem_write) begin
      mem[index] <= write_data;
    end
  end

  assign read_data = mem_read ? mem[index] : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_data_mem.sv
// tb_alu_ctrl_data_mem: scoreboard bench for ALU control and data memory.
// Revision 1.0 - initial release.
`default_nettype none

module clk_gen #(
  parameter int CLK_HALF = 5
) (
  output logic clk
);
  initial begin
    clk = 1'b0;
    forever #CLK_HALF clk = ~clk;
  end
endmodule

module tb_alu_ctrl_data_mem;

  localparam int CLK_HALF = 5;

  logic        clk;
  logic        rst;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [3:0]  operation;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] read_data;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp;
  longint      t_rise1 = -1;
  longint      t_rise2 = -1;

  clk_gen #(.CLK_HALF(CLK_HALF)) u_clk_gen (.clk(clk));

  alu_ctrl_data_mem #(.DEPTH(256), .ADDR_LSB(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_op     (alu_op),
    .funct      (funct),
    .operation  (operation),
    .address    (address),
    .write_data (write_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .read_data  (read_data)
  );

  initial begin
    @(posedge clk);
    t_rise1 = $time;
    @(posedge clk);
    t_rise2 = $time;
  end

  task automatic test_alu_basic();
    alu_op = 2'b00; funct = 6'b100010;
    sb_q.push_back(32'h2);
    #1;
    exp = sb_q.pop_front(); checks++;
    if ({28'h0, operation} !== exp) begin
      errors++; $display("FAIL aluop00 got=%h exp=%h", operation, exp[3:0]);
    end
    alu_op = 2'b01;
    sb_q.push_back(32'h6);
    #1;
    exp = sb_q.pop_front(); checks++;
    if ({28'h0, operation} !== exp) begin
      errors++; $display("FAIL aluop01 got=%h exp=%h", operation, exp[3:0]);
    end
  endtask

  task automatic test_alu_rtype();
    logic [5:0] f_tab [9];
    logic [3:0] o_tab [9];
    f_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
              6'b101010, 6'b000000, 6'b000010, 6'b111111};
    o_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100,
              4'b0111, 4'b1000, 4'b1001, 4'b0010};
    alu_op = 2'b10;
    for (int i = 0; i < 9; i++) begin
      funct = f_tab[i];
      sb_q.push_back({28'h0, o_tab[i]});
      #1;
      exp = sb_q.pop_front(); checks++;
      if ({28'h0, operation} !== exp) begin
        errors++;
        $display("FAIL rtype funct=%b got=%h exp=%h", funct, operation, exp[3:0]);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] a_tab [3];
    a_tab = '{32'd0, 32'd4, 32'd1020};
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      address = a_tab[i];
      sb_q.push_back(32'h0);
      #1;
      exp = sb_q.pop_front(); checks++;
      if (read_data !== exp) begin
        errors++; $display("FAIL reset_read addr=%0d got=%h exp=%h", address, read_data, exp);
      end
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    address = 32'd8; write_data = 32'hDEADBEEF; mem_write = 1'b1; mem_read = 1'b1;
    sb_q.push_back(32'h0);
    #1;
    exp = sb_q.pop_front(); checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL write_pre got=%h exp=%h", read_data, exp);
    end
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    sb_q.push_back(32'hDEADBEEF);
    #1;
    exp = sb_q.pop_front(); checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL write_post got=%h exp=%h", read_data, exp);
    end
    address = 32'd10;
    sb_q.push_back(32'hDEADBEEF);
    #1;
    exp = sb_q.pop_front(); checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL misaligned got=%h exp=%h", read_data, exp);
    end
    address = 32'd1032;
    sb_q.push_back(32'hDEADBEEF);
    #1;
    exp = sb_q.pop_front(); checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL wrap got=%h exp=%h", read_data, exp);
    end
  endtask

  task automatic test_read_enable();
    @(negedge clk);
    address = 32'd12; write_data = 32'h12345678; mem_write = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    mem_write = 1'b0;
    sb_q.push_back(32'h0);
    #1;
    exp = sb_q.pop_front(); checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL read_disabled got=%h exp=%h", read_data, exp);
    end
    mem_read = 1'b1;
    sb_q.push_back(32'h12345678);
    #1;
    exp = sb_q.pop_front(); checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL read_enabled got=%h exp=%h", read_data, exp);
    end
  endtask

  task automatic test_back_to_back();
    // Consecutive writes to distinct words, then read each back.
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      address = 32'(64 + 4 * i); write_data = 32'hA5A50000 + 32'(i); mem_write = 1'b1;
    end
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      address = 32'(64 + 4 * i);
      d = 32'hA5A50000 + 32'(i);
      sb_q.push_back(d);
      #1;
      exp = sb_q.pop_front(); checks++;
      if (read_data !== exp) begin
        errors++; $display("FAIL b2b idx=%0d got=%h exp=%h", i, read_data, exp);
      end
    end
  endtask

  task automatic test_rst_priority();
    @(negedge clk);
    address = 32'd0; write_data = 32'd5; mem_write = 1'b1; rst = 1'b1; mem_read = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_write = 1'b0;
    sb_q.push_back(32'h0);
    #1;
    exp = sb_q.pop_front(); checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL rst_priority got=%h exp=%h", read_data, exp);
    end
    address = 32'd12;
    sb_q.push_back(32'h0);
    #1;
    exp = sb_q.pop_front(); checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL rst_clears got=%h exp=%h", read_data, exp);
    end
  endtask

  task automatic test_clk_gen();
    checks++;
    if (t_rise1 != 64'(CLK_HALF)) begin
      errors++; $display("FAIL clk_first_rise got=%0d exp=%0d", t_rise1, CLK_HALF);
    end
    checks++;
    if (t_rise2 - t_rise1 != 64'(2 * CLK_HALF)) begin
      errors++; $display("FAIL clk_period got=%0d exp=%0d", t_rise2 - t_rise1, 2 * CLK_HALF);
    end
  endtask

  initial begin
    rst = 1'b0; alu_op = 2'b00; funct = 6'h0; address = 32'h0;
    write_data = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
    test_alu_basic();
    test_alu_rtype();
    test_reset();
    test_write();
    test_read_enable();
    test_back_to_back();
    test_rst_priority();
    test_clk_gen();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
